// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared constants for the PS/2 Set-2 scan-code decoder: prefix bytes,
// the codes that are discarded without an event, shift codes and FSM states.
package ps2_pkg;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_E1 = 8'hE1;
  localparam logic [7:0] PFX_F0 = 8'hF0;

  localparam logic [7:0] DISC_NUL  = 8'h00;
  localparam logic [7:0] DISC_BAT  = 8'hAA;
  localparam logic [7:0] DISC_ACK  = 8'hFA;
  localparam logic [7:0] DISC_RSND = 8'hFE;
  localparam logic [7:0] DISC_ERR  = 8'hFF;

  localparam logic [7:0] SHIFT_L = 8'h12;
  localparam logic [7:0] SHIFT_R = 8'h59;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FETCH  = 2'd1;
  localparam state_t ST_LATCH  = 2'd2;
  localparam state_t ST_DECODE = 2'd3;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == DISC_NUL) || (b == DISC_BAT) || (b == DISC_ACK) ||
           (b == DISC_RSND) || (b == DISC_ERR);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Pop handshake between the PS/2 receive FIFO and the scan-code decoder.
interface ps2_fifo_if;
  logic       ready;
  logic [7:0] data;
  logic       nextdata_n;

  modport master (input ready, input data, output nextdata_n);
  modport slave  (output ready, output data, input nextdata_n);
endinterface

// File: rtl/ps2_scancode_decoder_ascii.sv
// Combinational Set-2 make code to ASCII table; letters follow shift,
// digits only map unshifted.
module ps2_set2_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] lower;
  logic [7:0] digit;
  logic [7:0] other;

  always_comb begin
    lower = 8'h00;
    digit = 8'h00;
    other = 8'h00;
    case (code)
      8'h1C: lower = 8'h61;
      8'h32: lower = 8'h62;
      8'h21: lower = 8'h63;
      8'h23: lower = 8'h64;
      8'h24: lower = 8'h65;
      8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67;
      8'h33: lower = 8'h68;
      8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A;
      8'h42: lower = 8'h6B;
      8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D;
      8'h31: lower = 8'h6E;
      8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70;
      8'h15: lower = 8'h71;
      8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73;
      8'h2C: lower = 8'h74;
      8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76;
      8'h1D: lower = 8'h77;
      8'h22: lower = 8'h78;
      8'h35: lower = 8'h79;
      8'h1A: lower = 8'h7A;
      8'h45: digit = 8'h30;
      8'h16: digit = 8'h31;
      8'h1E: digit = 8'h32;
      8'h26: digit = 8'h33;
      8'h25: digit = 8'h34;
      8'h2E: digit = 8'h35;
      8'h36: digit = 8'h36;
      8'h3D: digit = 8'h37;
      8'h3E: digit = 8'h38;
      8'h46: digit = 8'h39;
      8'h29: other = 8'h20;
      8'h5A: other = 8'h0D;
      8'h66: other = 8'h08;
      default: other = 8'h00;
    endcase

    if (lower != 8'h00)
      ascii = shift ? (lower - 8'h20) : lower;
    else if (digit != 8'h00)
      ascii = shift ? 8'h00 : digit;
    else
      ascii = other;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: pops bytes from the receive FIFO and turns
// prefix sequences into single-cycle key events with held/shift tracking.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   IDLE      | wait for FIFO non-empty
//   FETCH     | nextdata_n low for one cycle (pop)
//   LATCH     | capture the popped byte
//   DECODE    | classify byte, update flags, maybe emit event
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int SKIP_E1 = 7
) (
  input  logic             clk,
  input  logic             clrn,
  ps2_fifo_if.master       fifo,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic [7:0]       ascii,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic             shift,
  output logic [CNT_W-1:0] press_count
);

  localparam int SKIP_W = (SKIP_E1 < 2) ? 1 : $clog2(SKIP_E1 + 1);

  state_t            state;
  logic [7:0]        byte_q;
  logic [SKIP_W-1:0] skip_cnt;
  logic              ext_f;
  logic              brk_f;
  logic              held_ext;
  logic              shift_l;
  logic              shift_r;
  logic [7:0]        ascii_lu;
  logic              is_shift;
  logic              held_match;

  ps2_set2_ascii u_ascii (
    .code  (byte_q),
    .shift (shift),
    .ascii (ascii_lu)
  );

  assign fifo.nextdata_n = (state != ST_FETCH);
  assign shift           = shift_l | shift_r;
  assign is_shift        = !ext_f && ((byte_q == SHIFT_L) || (byte_q == SHIFT_R));
  assign held_match      = key_held && (held_ext == ext_f) && (held_code == byte_q);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= ST_IDLE;
      byte_q      <= 8'h00;
      skip_cnt    <= '0;
      ext_f       <= 1'b0;
      brk_f       <= 1'b0;
      held_ext    <= 1'b0;
      shift_l     <= 1'b0;
      shift_r     <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      ascii       <= 8'h00;
      key_held    <= 1'b0;
      held_code   <= 8'h00;
      press_count <= '0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_IDLE: if (fifo.ready) state <= ST_FETCH;
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          byte_q <= fifo.data;
          state  <= ST_DECODE;
        end
        ST_DECODE: begin
          state <= ST_IDLE;
          if (skip_cnt != '0) begin
            skip_cnt <= skip_cnt - 1'b1;
          end else if (byte_q == PFX_E1) begin
            skip_cnt <= SKIP_W'(SKIP_E1);
            ext_f    <= 1'b0;
            brk_f    <= 1'b0;
          end else if (byte_q == PFX_E0) begin
            ext_f <= 1'b1;
          end else if (byte_q == PFX_F0) begin
            brk_f <= 1'b1;
          end else if (!is_discard(byte_q)) begin
            key_valid   <= 1'b1;
            key_code    <= byte_q;
            key_ext     <= ext_f;
            key_release <= brk_f;
            key_repeat  <= 1'b0;
            ascii       <= (ext_f || brk_f) ? 8'h00 : ascii_lu;
            ext_f       <= 1'b0;
            brk_f       <= 1'b0;
            if (is_shift) begin
              if (byte_q == SHIFT_L) shift_l <= !brk_f;
              else                   shift_r <= !brk_f;
            end else if (brk_f) begin
              if (held_match) key_held <= 1'b0;
            end else if (held_match) begin
              key_repeat <= 1'b1;
            end else begin
              key_held    <= 1'b1;
              held_code   <= byte_q;
              held_ext    <= ext_f;
              press_count <= press_count + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench: FIFO model feeds byte sequences, events are captured on
// the falling edge and compared against hand-computed values.
module tb_ps2_scancode_decoder;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_repeat;
  logic [7:0] ascii;
  logic       key_held;
  logic [7:0] held_code;
  logic       shift;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  ps2_fifo_if fif ();

  ps2_scancode_decoder #(.CNT_W(8), .SKIP_E1(7)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .fifo        (fif.master),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .key_repeat  (key_repeat),
    .ascii       (ascii),
    .key_held    (key_held),
    .held_code   (held_code),
    .shift       (shift),
    .press_count (press_count)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
    logic [7:0] asc;
    logic       held;
    logic [7:0] hcode;
    logic       shf;
    logic [7:0] cnt;
  } ev_t;

  logic [7:0] fifo_q[$];
  ev_t        evq[$];
  int         pop_lows = 0;
  int         n_chk = 0;
  int         n_bad = 0;

  // FIFO model: byte appears on data at the pop edge, ready reflects post-pop fill.
  always @(posedge clk) begin
    if (!fif.nextdata_n && fifo_q.size() != 0) begin
      fif.data <= fifo_q[0];
      void'(fifo_q.pop_front());
    end
    fif.ready <= (fifo_q.size() != 0);
  end

  always @(negedge clk) begin
    if (fif.nextdata_n === 1'b0) pop_lows++;
    if (key_valid === 1'b1)
      evq.push_back('{key_code, key_ext, key_release, key_repeat, ascii,
                      key_held, held_code, shift, press_count});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while ((fifo_q.size() != 0 || fif.ready !== 1'b0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) chk("drain_timeout", 32'(n), 32'(max_cyc - 1));
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    evq.delete();
    pop_lows = 0;
  endtask

  initial begin
    ev_t e;
    int  n;
    int  ev_before;
    logic [7:0] c;

    repeat (3) @(negedge clk);
    chk("rst_ndn", 32'(fif.nextdata_n), 32'h1);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_cnt", 32'(press_count), 32'h0);
    clrn = 1'b1;

    // make/break of 'a'
    do_reset();
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain(200);
    chk("t1_nev", 32'(evq.size()), 32'd2);
    e = evq[0];
    chk("t1_e0_code", 32'(e.code), 32'h1C);
    chk("t1_e0_rel", 32'(e.rel), 32'h0);
    chk("t1_e0_asc", 32'(e.asc), 32'h61);
    chk("t1_e0_cnt", 32'(e.cnt), 32'h1);
    chk("t1_e0_held", 32'(e.held), 32'h1);
    e = evq[1];
    chk("t1_e1_rel", 32'(e.rel), 32'h1);
    chk("t1_e1_asc", 32'(e.asc), 32'h00);
    chk("t1_e1_held", 32'(e.held), 32'h0);

    // shifted 'A'
    do_reset();
    push(8'h12); push(8'h1C); push(8'hF0); push(8'h12);
    drain(200);
    chk("t2_nev", 32'(evq.size()), 32'd3);
    chk("t2_shift_on", 32'(evq[0].shf), 32'h1);
    chk("t2_asc_A", 32'(evq[1].asc), 32'h41);
    chk("t2_cnt", 32'(evq[1].cnt), 32'h1);
    chk("t2_shift_off", 32'(evq[2].shf), 32'h0);
    chk("t2_shift_final", 32'(shift), 32'h0);

    // extended key
    do_reset();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain(200);
    chk("t3_nev", 32'(evq.size()), 32'd2);
    chk("t3_e0_ext", 32'(evq[0].ext), 32'h1);
    chk("t3_e0_asc", 32'(evq[0].asc), 32'h00);
    chk("t3_e0_rel", 32'(evq[0].rel), 32'h0);
    chk("t3_e0_hcode", 32'(evq[0].hcode), 32'h75);
    chk("t3_e1_ext", 32'(evq[1].ext), 32'h1);
    chk("t3_e1_rel", 32'(evq[1].rel), 32'h1);
    chk("t3_e1_held", 32'(evq[1].held), 32'h0);
    chk("t3_e1_code", 32'(evq[1].code), 32'h75);

    // typematic repeat
    do_reset();
    push(8'h1C); push(8'h1C); push(8'h1C);
    drain(200);
    chk("t4_nev", 32'(evq.size()), 32'd3);
    chk("t4_rep0", 32'(evq[0].rep), 32'h0);
    chk("t4_rep1", 32'(evq[1].rep), 32'h1);
    chk("t4_rep2", 32'(evq[2].rep), 32'h1);
    chk("t4_cnt", 32'(evq[2].cnt), 32'h1);
    chk("t4_pops", 32'(pop_lows), 32'd3);

    // pause sequence skipped, then space
    do_reset();
    push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
    push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
    push(8'h29);
    drain(300);
    chk("t5_nev", 32'(evq.size()), 32'd1);
    chk("t5_code", 32'(evq[0].code), 32'h29);
    chk("t5_asc", 32'(evq[0].asc), 32'h20);

    // reset during LATCH while state from t5 is non-zero
    push(8'h1C);
    n = 0;
    while (fif.nextdata_n !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_fetch_seen", 32'(fif.nextdata_n), 32'h0);
    ev_before = evq.size();
    @(posedge clk);
    #1 clrn = 1'b0;
    #1;
    chk("t6_ndn", 32'(fif.nextdata_n), 32'h1);
    chk("t6_code", 32'(key_code), 32'h00);
    chk("t6_asc", 32'(ascii), 32'h00);
    chk("t6_held", 32'(key_held), 32'h0);
    chk("t6_hcode", 32'(held_code), 32'h00);
    chk("t6_cnt", 32'(press_count), 32'h00);
    chk("t6_flags", 32'({key_valid, key_ext, key_release, key_repeat, shift}), 32'h0);
    repeat (3) @(negedge clk);
    chk("t6_no_event", 32'(evq.size()), 32'(ev_before));
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_no_event_after", 32'(evq.size()), 32'(ev_before));
    evq.delete();
    push(8'h1D);
    drain(200);
    chk("t6_nev", 32'(evq.size()), 32'd1);
    chk("t6_post_code", 32'(evq[0].code), 32'h1D);
    chk("t6_post_asc", 32'(evq[0].asc), 32'h77);
    chk("t6_post_cnt", 32'(evq[0].cnt), 32'h1);

    // digits, shifted digit, enter, discard between F0 and code
    do_reset();
    push(8'h16); push(8'h12); push(8'h16); push(8'hF0); push(8'h12);
    push(8'h5A); push(8'hF0); push(8'hAA); push(8'h1C);
    drain(300);
    chk("t7_nev", 32'(evq.size()), 32'd6);
    chk("t7_digit", 32'(evq[0].asc), 32'h31);
    chk("t7_shift_ev_asc", 32'(evq[1].asc), 32'h00);
    chk("t7_sdigit", 32'(evq[2].asc), 32'h00);
    chk("t7_sdigit_rep", 32'(evq[2].rep), 32'h1);
    chk("t7_enter", 32'(evq[4].asc), 32'h0D);
    chk("t7_enter_cnt", 32'(evq[4].cnt), 32'h2);
    chk("t7_disc_rel", 32'(evq[5].rel), 32'h1);
    chk("t7_disc_code", 32'(evq[5].code), 32'h1C);
    chk("t7_nomatch_held", 32'(evq[5].held), 32'h1);
    chk("t7_nomatch_hcode", 32'(evq[5].hcode), 32'h5A);

    // press_count wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      c = 8'h13 + 8'(i % 64);
      if (i >= 128) push(8'hE0);
      push(c);
      if (i >= 128) push(8'hE0);
      push(8'hF0);
      push(c);
      if (i == 254) begin
        drain(20000);
        chk("t8_cnt_255", 32'(press_count), 32'd255);
      end
    end
    drain(2000);
    chk("t8_nev", 32'(evq.size()), 32'd512);
    chk("t8_wrap", 32'(press_count), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Consumes scan-code bytes from the PS/2 receive FIFO stage (its data/ready/nextdata_n interface) and turns PS/2 Set-2 byte sequences into single-cycle key events.
- Tracks the E0 (extended) and F0 (break) prefixes.
- Tracks shift state and detects typematic repeat.
- Translates a subset of codes to ASCII.
- Counts distinct key presses.

Feeds the display/LED logic and any CPU-side keyboard register.

Parameters:
- CNT_W, 8, width of press_count; wraps modulo 2^CNT_W.
- SKIP_E1, 7, number of bytes discarded after an E1 (Pause) prefix.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- ready  in  1  receive FIFO non-empty
- data  in  8  scan-code byte; valid the cycle after nextdata_n was low
- nextdata_n  out  1  active-low, one-cycle pop request to the FIFO
- key_valid  out  1  one-cycle pulse: event outputs valid
- key_code  out  8  final (non-prefix) scan code of the event
- key_ext  out  1  event was E0-prefixed
- key_release  out  1  event was F0-prefixed (break)
- key_repeat  out  1  make of the currently held key (typematic)
- ascii  out  8  ASCII of the event; 0x00 if unmapped, extended or release
- key_held  out  1  a non-modifier key is currently held
- held_code  out  8  code of the held key
- shift  out  1  left (0x12) or right (0x59) shift held
- press_count  out  CNT_W  non-repeat, non-modifier make events

Behaviour:
- Reset is asynchronous on clrn=0. All registers clear immediately:
  - nextdata_n=1; key_valid=0.
  - key_code, ascii, held_code = 0x00; all flags = 0; press_count=0; FSM to IDLE.
- Reset mid-handshake abandons the byte; no event is emitted.
- FSM states: IDLE, FETCH, LATCH, DECODE.
  - IDLE: if ready=1, go to FETCH.
  - FETCH: nextdata_n=0 for exactly this cycle (decoded from the state register); go to LATCH.
  - LATCH: capture data into a byte register; go to DECODE.
  - DECODE: classify the byte and update state; go to IDLE.
- Throughput: at most one byte per 4 cycles.
- ready is sampled only in IDLE. The FIFO updates ready at the pop edge, so a stale ready cannot cause a double pop.
- nextdata_n is never low outside FETCH.
- Classification in DECODE, in this priority:
  1. skip_cnt≠0: decrement, discard the byte.
  2. 0xE1: skip_cnt=SKIP_E1; clear ext_f/brk_f.
  3. 0xE0: ext_f=1.
  4. 0xF0: brk_f=1.
  5. 0x00, 0xAA, 0xFA, 0xFE, 0xFF: discard; prefix flags unchanged.
  6. Anything else is final. key_valid=1 on the following cycle, with key_code=byte, key_ext=ext_f, key_release=brk_f. Then clear ext_f and brk_f.
- Event fields hold their value until the next event; only key_valid pulses.
- Shift keys (0x12, 0x59, non-extended):
  - The event is emitted.
  - Make sets the corresponding shift bit; break clears it. shift = OR of both bits.
  - Shift keys do not affect key_held or press_count.
- Other make events:
  - If key_held=1 and {ext,code} equals the held key: key_repeat=1, press_count unchanged.
  - Otherwise: key_held=1, held_code/held_ext updated, press_count+1 (wrapping).
- Break events:
  - Matching the held key clears key_held.
  - A non-matching break has no effect on key_held.
- key_repeat is 0 for breaks.
- ASCII: combinational lookup on the non-extended make code, shift-qualified.
  - Letters: lower case, upper case if shift. For example 0x1C→0x61 'a' / 0x41 'A'.
  - Digits: 0x45→0x30 through 0x46→0x39 (Set-2 row); unshifted only, shifted gives 0x00.
  - 0x29→0x20 (space); 0x5A→0x0D (enter); 0x66→0x08 (backspace).
  - Everything else, and all extended or break events, → 0x00.

Decomposition:
- Package ps2_pkg holds:
  - localparams for prefix bytes (E0, E1, F0), the discard codes and the shift codes.
  - the FSM state enum.
- Sub-module ps2_set2_ascii: purely combinational {code, shift} → ascii table.
- The decoder FSM, flags and counters stay in the top module.

Test Plan:
- Bytes 1C, F0 1C through a FIFO model. Expect:
  - event 1: key_code=0x1C, release=0, ascii=0x61, press_count=1, key_held=1.
  - event 2: release=1, ascii=0x00, key_held=0.
- Bytes 12, 1C, F0 12. Expect:
  - shift=1 after the first event.
  - second event ascii=0x41, press_count=1.
  - shift=0 after F0 12.
- Bytes E0 75, E0 F0 75. Expect key_ext=1 and ascii=0x00 on both events, release 0 then 1, held_code=0x75.
- Bytes 1C, 1C, 1C. Expect three events, key_repeat=0,1,1, press_count=1. Check nextdata_n is low exactly 3 cycles in total.
- Bytes E1 14 77 E1 F0 14 F0 77 then 29. Expect exactly one event: code 0x29, ascii 0x20.
- Drive clrn=0 during LATCH with FIFO byte 0x1C pending. Expect:
  - all outputs zero and nextdata_n=1 immediately, with no event.
  - after release, the next byte decodes normally.
- 256 distinct make/break pairs. Expect press_count to wrap to 0.
